hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Generates per-stage register enables and flushes for three cases:
  - load-use bubbles, the only data stall left once forwarding is in place;
  - taken-branch/jump wrong-path squashes;
  - whole-pipeline freezes while a multi-cycle data-memory access is outstanding.
- Adds a memory-timeout watchdog that halts the core, plus saturating performance counters.
- Sits beside the forwarding logic and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- MEM_TIMEOUT, 16: consecutive frozen cycles on one access before HALT; 0 disables the watchdog.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ifid_rs1  in  5  rs1 of instruction in ID
- ifid_rs2  in  5  rs2 of instruction in ID
- ifid_rs1_used  in  1  ID instruction actually reads rs1
- ifid_rs2_used  in  1  ID instruction actually reads rs2
- idex_memRead  in  1  instruction in EX is a load
- idex_rd  in  5  destination of instruction in EX
- ex_branch_taken  in  1  EX resolves a taken branch or jump (redirect)
- exmem_memAccess  in  1  instruction in MEM issues a data-memory request
- dmem_ready  in  1  data memory completes the request this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_en  out  1  ID/EX register enable
- idex_flush  out  1  ID/EX loads a bubble
- exmem_en  out  1  EX/MEM register enable
- memwb_flush  out  1  MEM/WB loads a bubble
- halted  out  1  watchdog tripped
- stall_cycles  out  CNT_W  cycles with pc_en=0 outside HALT
- flush_count  out  CNT_W  applied branch flushes
- loaduse_count  out  CNT_W  inserted load-use bubbles

Behaviour:
- Reset (asynchronous, held while rst=1):
  - state=RUN; wait_cnt=0; all counters=0; halted=0.
  - Outputs: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_flush=memwb_flush=1.
- States: RUN, MEM_WAIT, HALT.
- Combinational terms:
  - freeze = exmem_memAccess & ~dmem_ready.
  - lu = idex_memRead & idex_rd≠0 & ((ifid_rs1_used & ifid_rs1==idex_rd) | (ifid_rs2_used & ifid_rs2==idex_rd)).
- Default outputs in RUN/MEM_WAIT: all enables=1, all flushes=0.
- Priority, highest first: HALT > freeze > branch > load-use.
  - freeze: pc_en=ifid_en=idex_en=exmem_en=0; memwb_flush=1, so the WB instruction is never written twice. Branch and load-use are ignored this cycle; both re-evaluate once the freeze releases, since their instructions have not moved.
  - ex_branch_taken & ~freeze: ifid_flush=1, idex_flush=1; PC takes the redirect. Load-use is suppressed because the ID instruction is on the wrong path. flush_count+1.
  - lu & ~freeze & ~branch: pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle; next cycle the load is in MEM and lu clears. loaduse_count+1.
- Transitions:
  - RUN, freeze:
    - MEM_TIMEOUT==1: go to HALT.
    - otherwise: wait_cnt<=1, go to MEM_WAIT.
  - MEM_WAIT, freeze:
    - wait_cnt+1==MEM_TIMEOUT: go to HALT.
    - otherwise: wait_cnt<=wait_cnt+1.
  - MEM_WAIT, ~freeze: go to RUN, wait_cnt<=0. The pipeline advances normally in that ready cycle.
  - MEM_TIMEOUT==0: never enter HALT; wait_cnt saturates.
  - HALT: terminal until rst. halted=1; all enables=0, all flushes=0; counters frozen.
- stall_cycles increments on every non-HALT cycle with pc_en=0.
- All counters saturate at all-ones and never wrap.
- Outputs are combinational from state and inputs; the only registers are state, wait_cnt, counters and halted.
- rst asserted mid-wait aborts the wait immediately; no state survives.

Decomposition:
- Shared pipeline package holds:
  - state encoding localparams ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_HALT=2'd2;
  - the REG_ZERO=5'd0 constant, shared with the forwarding logic.
- One natural sub-module: sat_counter, parameterised width with an increment enable; instantiated three times.

Test Plan:
- Load-use: EX holds a load, idex_rd=5; ID has rs1=5, used=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all clear; loaduse_count=1.
- Zero register and unused operand: idex_rd=0, or rs2=5 with rs2_used=0 -> no stall; counters stay 0.
- Branch and load-use together: ex_branch_taken=1 with the load-use condition true -> ifid_flush=idex_flush=1, pc_en=1; flush_count=1, loaduse_count=0.
- Memory wait: exmem_memAccess=1, dmem_ready low 3 cycles then high, MEM_TIMEOUT=16 -> 3 frozen cycles with memwb_flush=1, state back to RUN, stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4, dmem_ready held 0 -> halted=1 from cycle 4 onward and all enables 0; assert rst -> halted=0, counters 0.
- Async reset mid-MEM_WAIT: pulse rst between clock edges -> outputs take reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline constants and types for the hazard sequencer.
// Also provides the zero-register index used by the forwarding logic.
package hazard_controller_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    S_RUN      = ST_RUN,
    S_MEM_WAIT = ST_MEM_WAIT,
    S_HALT     = ST_HALT
  } state_e;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with increment enable.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch squashes, memory freezes, timeout watchdog and perf counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_rs1_used,
  input  logic             ifid_rs2_used,
  input  logic             idex_memRead,
  input  logic [4:0]       idex_rd,
  input  logic             ex_branch_taken,
  input  logic             exmem_memAccess,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] loaduse_count
);

  localparam int WC_W =
    (MEM_TIMEOUT < 2) ? 2 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W:0] TO_V = (WC_W+1)'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;
  logic            halted_q, halted_d;
  logic [WC_W:0]   wc_inc;

  logic freeze, lu;
  logic stall_inc, flush_inc, lu_inc;

  assign freeze = exmem_memAccess & ~dmem_ready;
  assign lu = idex_memRead & (idex_rd != REG_ZERO) &
    ((ifid_rs1_used & (ifid_rs1 == idex_rd)) |
     (ifid_rs2_used & (ifid_rs2 == idex_rd)));
  assign wc_inc = {1'b0, wait_q} + 1'b1;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    flush_inc   = 1'b0;
    lu_inc      = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == S_HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (freeze) begin
      // WB still retires its result, so bubble MEM/WB to avoid a double write
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      lu_inc     = 1'b1;
    end
  end

  assign stall_inc = ~rst & (state_q != S_HALT) & ~pc_en;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    halted_d = halted_q;
    unique case (state_q)
      S_RUN: begin
        if (freeze) begin
          if (MEM_TIMEOUT == 1) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            wait_d  = WC_W'(1);
            state_d = S_MEM_WAIT;
          end
        end
      end
      S_MEM_WAIT: begin
        if (!freeze) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else if (MEM_TIMEOUT != 0 && wc_inc == TO_V) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (!(&wait_q)) begin
          wait_d = wc_inc[WC_W-1:0];
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      wait_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc_i(stall_inc), .cnt_o(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc_i(flush_inc), .cnt_o(flush_count)
  );
  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst(rst), .inc_i(lu_inc), .cnt_o(loaduse_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a scoreboard queue;
// a second instance with a short timeout exercises the watchdog.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic ifid_rs1_used, ifid_rs2_used, idex_memRead;
  logic ex_branch_taken, exmem_memAccess, dmem_ready;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, memwb_flush, halted;
  logic [31:0] stall_cycles, flush_count, loaduse_count;

  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
  logic w_exmem_en, w_memwb_flush, w_halted;
  logic [31:0] w_stall_cycles, w_flush_count, w_loaduse_count;

  logic [6:0] ctl, w_ctl;
  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en,
                idex_flush, exmem_en, memwb_flush};
  assign w_ctl = {w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en,
                  w_idex_flush, w_exmem_en, w_memwb_flush};

  localparam logic [6:0] C_NORM = 7'b1101010;
  localparam logic [6:0] C_RST  = 7'b0010101;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_HLT  = 7'b0000000;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
    .idex_memRead(idex_memRead), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken),
    .exmem_memAccess(exmem_memAccess), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .loaduse_count(loaduse_count)
  );

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut4 (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
    .idex_memRead(idex_memRead), .idex_rd(idex_rd),
    .ex_branch_taken(ex_branch_taken),
    .exmem_memAccess(exmem_memAccess), .dmem_ready(dmem_ready),
    .pc_en(w_pc_en), .ifid_en(w_ifid_en), .ifid_flush(w_ifid_flush),
    .idex_en(w_idex_en), .idex_flush(w_idex_flush),
    .exmem_en(w_exmem_en), .memwb_flush(w_memwb_flush),
    .halted(w_halted), .stall_cycles(w_stall_cycles),
    .flush_count(w_flush_count), .loaduse_count(w_loaduse_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } sb_t;

  sb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic push(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got %0h want <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: got %0h want %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic set_in(
    input logic mr, input logic [4:0] rd,
    input logic [4:0] r1, input logic u1,
    input logic [4:0] r2, input logic u2,
    input logic br, input logic ma, input logic rdy
  );
    idex_memRead    = mr;
    idex_rd         = rd;
    ifid_rs1        = r1;
    ifid_rs1_used   = u1;
    ifid_rs2        = r2;
    ifid_rs2_used   = u2;
    ex_branch_taken = br;
    exmem_memAccess = ma;
    dmem_ready      = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] c);
    push(tag, {25'd0, c});
    #1;
    check({25'd0, ctl});
  endtask

  task automatic chk_cnt(
    input logic [31:0] s, input logic [31:0] f, input logic [31:0] l
  );
    push("stall_cycles", s);
    check(stall_cycles);
    push("flush_count", f);
    check(flush_count);
    push("loaduse_count", l);
    check(loaduse_count);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    #2;
    chk_ctl("reset_ctl", C_RST);
    push("reset_halted", 32'd0);
    check({31'd0, halted});
    chk_cnt(0, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    chk_ctl("idle", C_NORM);
    cyc();

    // load-use: one bubble then clear
    set_in(1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0);
    chk_ctl("loaduse", C_LU);
    cyc();
    set_in(0, 5'd0, 5'd5, 1, 5'd0, 0, 0, 0, 0);
    chk_ctl("loaduse_clear", C_NORM);
    chk_cnt(1, 0, 1);
    cyc();

    // zero register and unused operand
    set_in(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    chk_ctl("x0_no_stall", C_NORM);
    cyc();
    set_in(1, 5'd5, 5'd3, 1, 5'd5, 0, 0, 0, 0);
    chk_ctl("rs2_unused", C_NORM);
    cyc();
    chk_cnt(1, 0, 1);

    // branch beats load-use
    set_in(1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 0);
    chk_ctl("branch_over_lu", C_BR);
    cyc();
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    chk_cnt(1, 1, 1);

    // memory wait 3 cycles, branch held pending
    for (int i = 0; i < 3; i++) begin
      set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0);
      chk_ctl($sformatf("freeze_%0d", i), C_FRZ);
      cyc();
    end
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1);
    chk_ctl("mem_ready_branch", C_BR);
    cyc();
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    chk_cnt(4, 2, 1);
    push("state_run", {30'd0, ST_RUN});
    check({30'd0, dut.state_q});
    chk_ctl("after_wait", C_NORM);
    cyc();

    // watchdog on the short-timeout instance
    for (int i = 0; i < 4; i++) begin
      set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      #1;
      push($sformatf("wd_ctl_%0d", i), {25'd0, C_FRZ});
      check({25'd0, w_ctl});
      push($sformatf("wd_halted_%0d", i), 32'd0);
      check({31'd0, w_halted});
      cyc();
    end
    push("wd_halted", 32'd1);
    check({31'd0, w_halted});
    push("wd_halt_ctl", {25'd0, C_HLT});
    check({25'd0, w_ctl});
    chk_ctl("long_freeze_16", C_FRZ);
    cyc();
    cyc();
    push("wd_stall_frozen", 32'd8);
    check(w_stall_cycles);
    push("wd_still_halted", 32'd1);
    check({31'd0, w_halted});

    // async reset between edges while waiting
    rst = 1'b1;
    chk_ctl("async_rst_ctl", C_RST);
    push("async_rst_halted", 32'd0);
    check({31'd0, w_halted});
    push("async_rst_wd_stall", 32'd0);
    check(w_stall_cycles);
    chk_cnt(0, 0, 0);
    push("async_rst_state", {30'd0, ST_RUN});
    check({30'd0, dut.state_q});
    rst = 1'b0;
    set_in(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    chk_ctl("post_rst_idle", C_NORM);
    cyc();
    chk_cnt(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
